// File: rtl/pdm_waveform_sequencer.sv
// ---------------------------------------------------------------------------
// pdm_waveform_sequencer
//
// Plays a writable waveform table into the mod_setpoint input of one
// pdm_modulator. The table index only moves on pdm_start_strobe, so the
// modulator never sees its setpoint change in the middle of a PDM period.
// Supports one-shot and looped playback, a programmable hold of
// cfg_hold+1 periods per sample, and abort.
//
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   wr_en/addr/data    table write port (allowed in any state)
//   cfg_len            index of the last sample played (length-1)
//   cfg_hold           each sample is held cfg_hold+1 PDM periods
//   cfg_loop           1 = wrap to index 0 after the last sample
//   play / stop        start / abort pulses (stop wins)
//   pdm_start_strobe   one-cycle pulse at each PDM period start
//   mod_setpoint       registered setpoint to the modulator
//   sample_idx         index of the sample currently driven
//   running            high while armed or playing
//   done               one-cycle pulse when a one-shot finishes
// ---------------------------------------------------------------------------
module pdm_waveform_sequencer #(
    parameter int MOD_WIDTH  = 5,
    parameter int ADDR_WIDTH = 5,
    parameter int HOLD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [MOD_WIDTH-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0] cfg_len,
    input  logic [HOLD_WIDTH-1:0] cfg_hold,
    input  logic                  cfg_loop,
    input  logic                  play,
    input  logic                  stop,
    input  logic                  pdm_start_strobe,
    output logic [MOD_WIDTH-1:0]  mod_setpoint,
    output logic [ADDR_WIDTH-1:0] sample_idx,
    output logic                  running,
    output logic                  done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                  state;
    logic [MOD_WIDTH-1:0]    tbl [DEPTH];

    // Configuration captured at play; live cfg_* is ignored while running.
    logic [ADDR_WIDTH-1:0]   len_sh;
    logic [HOLD_WIDTH-1:0]   hold_sh;
    logic                    loop_sh;

    logic [HOLD_WIDTH-1:0]   hold_cnt;
    logic [ADDR_WIDTH-1:0]   next_idx;
    logic                    hold_done;
    logic                    last_sample;

    assign next_idx    = sample_idx + ADDR_WIDTH'(1);
    assign hold_done   = (hold_cnt == hold_sh);
    assign last_sample = (sample_idx == len_sh);

    // Table: no reset, synchronous write, combinational read. A fetch on the
    // same edge as a write to that address sees the old contents because the
    // read happens before the write's non-blocking update lands.
    always_ff @(posedge clk) begin
        if (wr_en)
            tbl[wr_addr] <= wr_data;
    end

    // Sequencer FSM. Priority per cycle: stop > strobe handling > play.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= S_IDLE;
            mod_setpoint <= '0;
            sample_idx   <= '0;
            running      <= 1'b0;
            done         <= 1'b0;
            hold_cnt     <= '0;
            len_sh       <= '0;
            hold_sh      <= '0;
            loop_sh      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop && (state != S_IDLE)) begin
                // Abort: silent return to idle, no done pulse.
                state        <= S_IDLE;
                mod_setpoint <= '0;
                sample_idx   <= '0;
                running      <= 1'b0;
                hold_cnt     <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // stop in the same cycle as play keeps us idle.
                        if (play && !stop) begin
                            len_sh  <= cfg_len;
                            hold_sh <= cfg_hold;
                            loop_sh <= cfg_loop;
                            running <= 1'b1;
                            state   <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        // First sample goes out aligned to a period start.
                        if (pdm_start_strobe) begin
                            state        <= S_RUN;
                            mod_setpoint <= tbl[0];
                            sample_idx   <= '0;
                            hold_cnt     <= '0;
                        end
                    end
                    S_RUN: begin
                        if (pdm_start_strobe) begin
                            if (!hold_done) begin
                                // hold_cnt stops at hold_sh, so it can't wrap.
                                hold_cnt <= hold_cnt + HOLD_WIDTH'(1);
                            end else if (!last_sample) begin
                                hold_cnt     <= '0;
                                sample_idx   <= next_idx;
                                mod_setpoint <= tbl[next_idx];
                            end else if (loop_sh) begin
                                hold_cnt     <= '0;
                                sample_idx   <= '0;
                                mod_setpoint <= tbl[0];
                            end else begin
                                state        <= S_IDLE;
                                hold_cnt     <= '0;
                                sample_idx   <= '0;
                                mod_setpoint <= '0;
                                running      <= 1'b0;
                                done         <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state        <= S_IDLE;
                        mod_setpoint <= '0;
                        sample_idx   <= '0;
                        running      <= 1'b0;
                        hold_cnt     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pdm_waveform_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pdm_waveform_sequencer
//
// Directed bench for pdm_waveform_sequencer. Inputs are driven 1 ns after
// each rising edge, and outputs are sampled at that same point, so every
// check sees the result of the preceding edge.
// ---------------------------------------------------------------------------
module tb_pdm_waveform_sequencer;

    localparam int MW = 5;
    localparam int AW = 5;
    localparam int HW = 8;

    logic          clk;
    logic          nrst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [MW-1:0] wr_data;
    logic [AW-1:0] cfg_len;
    logic [HW-1:0] cfg_hold;
    logic          cfg_loop;
    logic          play;
    logic          stop;
    logic          pdm_start_strobe;
    logic [MW-1:0] mod_setpoint;
    logic [AW-1:0] sample_idx;
    logic          running;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    pdm_waveform_sequencer #(.MOD_WIDTH(MW), .ADDR_WIDTH(AW), .HOLD_WIDTH(HW)) dut (
        .clk              (clk),
        .nrst             (nrst),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .cfg_len          (cfg_len),
        .cfg_hold         (cfg_hold),
        .cfg_loop         (cfg_loop),
        .play             (play),
        .stop             (stop),
        .pdm_start_strobe (pdm_start_strobe),
        .mod_setpoint     (mod_setpoint),
        .sample_idx       (sample_idx),
        .running          (running),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = MW'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load4(input int d0, input int d1, input int d2, input int d3);
        wr(0, d0); wr(1, d1); wr(2, d2); wr(3, d3);
    endtask

    task automatic do_play(input int len, input int hold, input bit lp);
        cfg_len = AW'(len); cfg_hold = HW'(hold); cfg_loop = lp;
        play = 1'b1;
        tick();
        play = 1'b0;
    endtask

    // One strobe cycle; outputs reflect it when this returns. The gap
    // afterwards is done separately so checks land right after the strobe.
    task automatic strobe();
        pdm_start_strobe = 1'b1;
        tick();
        pdm_start_strobe = 1'b0;
    endtask

    initial begin
        int exp_sp;
        nrst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cfg_len = '0; cfg_hold = '0; cfg_loop = 1'b0;
        play = 1'b0; stop = 1'b0; pdm_start_strobe = 1'b0;
        #12;
        chk("rst_setpoint", mod_setpoint, 0);
        chk("rst_idx", sample_idx, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        nrst = 1'b1;
        tick();

        // Idle: strobes ignored; stop+play together stays idle.
        strobe();
        chk("idle_strobe_sp", mod_setpoint, 0);
        stop = 1'b1; play = 1'b1;
        tick();
        stop = 1'b0; play = 1'b0;
        chk("stop_play_idle_running", running, 0);

        // One-shot, hold 0.
        load4(16, 19, 22, 25);
        do_play(3, 0, 1'b0);
        chk("t1_running_arm", running, 1);
        chk("t1_arm_sp", mod_setpoint, 0);
        for (int s = 0; s < 4; s++) begin
            strobe();
            exp_sp = 16 + 3 * s;
            chk($sformatf("t1_sp%0d", s), mod_setpoint, exp_sp);
            chk($sformatf("t1_idx%0d", s), sample_idx, s);
            chk($sformatf("t1_done%0d", s), done, 0);
            idle(5);
        end
        strobe();
        chk("t1_done", done, 1);
        chk("t1_end_sp", mod_setpoint, 0);
        chk("t1_end_running", running, 0);
        tick();
        chk("t1_done_1cyc", done, 0);

        // One-shot, hold 2: each sample for 3 strobes, done on strobe 13.
        do_play(3, 2, 1'b0);
        for (int s = 1; s <= 12; s++) begin
            strobe();
            exp_sp = 16 + 3 * ((s - 1) / 3);
            chk($sformatf("t2_sp%0d", s), mod_setpoint, exp_sp);
            chk($sformatf("t2_done%0d", s), done, 0);
            idle(2);
        end
        strobe();
        chk("t2_done13", done, 1);
        chk("t2_running13", running, 0);
        tick();

        // cfg_len=0: single sample then done.
        do_play(0, 0, 1'b0);
        strobe();
        chk("len0_sp", mod_setpoint, 16);
        idle(2);
        strobe();
        chk("len0_done", done, 1);
        tick();

        // Loop, len 1: 31,0,31,0...
        wr(0, 31); wr(1, 0);
        do_play(1, 0, 1'b1);
        for (int s = 0; s < 8; s++) begin
            strobe();
            exp_sp = (s % 2 == 0) ? 31 : 0;
            chk($sformatf("t3_sp%0d", s), mod_setpoint, exp_sp);
            chk($sformatf("t3_done%0d", s), done, 0);
            idle(3);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_stop_running", running, 0);
        chk("t3_stop_done", done, 0);

        // Stop coincident with a strobe at idx 2.
        load4(16, 19, 22, 25);
        do_play(3, 0, 1'b0);
        for (int s = 0; s < 3; s++) begin strobe(); idle(2); end
        chk("t4_idx2", sample_idx, 2);
        stop = 1'b1; pdm_start_strobe = 1'b1;
        tick();
        stop = 1'b0; pdm_start_strobe = 1'b0;
        chk("t4_sp", mod_setpoint, 0);
        chk("t4_idx", sample_idx, 0);
        chk("t4_running", running, 0);
        chk("t4_done", done, 0);
        strobe();
        chk("t4_later_sp", mod_setpoint, 0);
        chk("t4_later_done", done, 0);

        // Live table write, cfg change mid-run, play ignored while running,
        // same-edge write/fetch returns old data.
        do_play(3, 0, 1'b0);
        strobe();
        play = 1'b1; tick(); play = 1'b0;
        chk("t5_play_ignored_idx", sample_idx, 0);
        chk("t5_play_ignored_sp", mod_setpoint, 16);
        strobe();
        chk("t5_idx1", sample_idx, 1);
        wr(2, 7);
        cfg_len = '0; cfg_hold = 8'd5;
        strobe();
        chk("t5_new_data", mod_setpoint, 7);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 5'd13; pdm_start_strobe = 1'b1;
        tick();
        wr_en = 1'b0; pdm_start_strobe = 1'b0;
        chk("t5_old_on_collision", mod_setpoint, 25);
        chk("t5_latched_len_nodone", done, 0);
        strobe();
        chk("t5_done", done, 1);
        tick();

        // Asynchronous reset mid-run.
        do_play(3, 0, 1'b0);
        strobe(); idle(1); strobe();
        chk("t6_pre_sp", mod_setpoint, 19);
        #3 nrst = 1'b0;
        #1;
        chk("t6_async_sp", mod_setpoint, 0);
        chk("t6_async_idx", sample_idx, 0);
        chk("t6_async_running", running, 0);
        #2 nrst = 1'b1;
        tick();
        do_play(3, 0, 1'b0);
        chk("t6_rearm_running", running, 1);
        strobe();
        chk("t6_restart_sp", mod_setpoint, 16);
        chk("t6_restart_idx", sample_idx, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
